teclado_cajero: RTL

Keypad front-end for `cajero_automatico`, placed directly upstream of it. It synchronizes and debounces one raw key from the keypad encoder. In PIN mode it emits one-cycle `DIGITO_STB`/`DIGITO` per keypress. In amount mode it accumulates decimal digits and emits the committed value on `MONTO`/`MONTO_STB` when ENTER is pressed. Its outputs connect one-to-one to the same-named inputs of `cajero_automatico`.

---
 rtl/teclado_cajero.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/teclado_cajero.sv
// Keypad front-end: synchronizes and debounces one raw key, then emits PIN digits
// or accumulates a decimal amount and commits it on ENTER.
module teclado_cajero #(
  parameter int DEBOUNCE_CICLOS   = 4,
  parameter int MAX_DIGITOS_MONTO = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TECLA_ACTIVA,
  input  logic [3:0]  TECLA,
  input  logic        MODO_MONTO,
  output logic        DIGITO_STB,
  output logic [3:0]  DIGITO,
  output logic        MONTO_STB,
  output logic [31:0] MONTO,
  output logic        TECLA_INVALIDA
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int DW = $clog2(MAX_DIGITOS_MONTO + 1);

  localparam logic [3:0] K_ENTER  = 4'hA;
  localparam logic [3:0] K_BORRAR = 4'hB;

  typedef enum logic [1:0] {REPOSO, FILTRANDO, ACEPTADA, ESPERA_SOLTAR} estado_t;

  estado_t        estado, estado_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           act_m, act_s;
  logic [3:0]     tec_m, tec_s, tec_q;
  logic           modo_q;
  logic [31:0]    acc, acc_d, acc_base;
  logic [DW-1:0]  ndig, ndig_d, ndig_base;
  logic           dig_stb_d, monto_stb_d, inv_d;
  logic [3:0]     digito_d;
  logic [31:0]    monto_d;
  logic           aceptar, modo_cambio;

  // NOTE: every register uses non-blocking assignment so all state updates
  // see the pre-edge values, matching real flip-flop behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_m          <= 1'b0;
      act_s          <= 1'b0;
      tec_m          <= '0;
      tec_s          <= '0;
      tec_q          <= '0;
      modo_q         <= 1'b0;
      estado         <= REPOSO;
      cnt            <= '0;
      acc            <= '0;
      ndig           <= '0;
      DIGITO_STB     <= 1'b0;
      DIGITO         <= '0;
      MONTO_STB      <= 1'b0;
      MONTO          <= '0;
      TECLA_INVALIDA <= 1'b0;
    end else begin
      act_m          <= TECLA_ACTIVA;
      act_s          <= act_m;
      tec_m          <= TECLA;
      tec_s          <= tec_m;
      tec_q          <= tec_s;
      modo_q         <= MODO_MONTO;
      estado         <= estado_d;
      cnt            <= cnt_d;
      acc            <= acc_d;
      ndig           <= ndig_d;
      DIGITO_STB     <= dig_stb_d;
      DIGITO         <= digito_d;
      MONTO_STB      <= monto_stb_d;
      MONTO          <= monto_d;
      TECLA_INVALIDA <= inv_d;
    end
  end

  // NOTE: defaults at the top of each always_comb keep every path assigned,
  // so no latches are inferred.
  always_comb begin
    estado_d = estado;
    cnt_d    = cnt;
    unique case (estado)
      REPOSO: begin
        cnt_d = '0;
        if (act_s) begin
          estado_d = FILTRANDO;
          cnt_d    = CW'(1);
        end
      end
      FILTRANDO: begin
        if (!act_s) begin
          estado_d = REPOSO;
          cnt_d    = '0;
        end else if (tec_s != tec_q) begin
          cnt_d = CW'(1);
        end else if (cnt == CW'(DEBOUNCE_CICLOS - 1)) begin
          estado_d = ACEPTADA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ACEPTADA: begin
        estado_d = ESPERA_SOLTAR;
        cnt_d    = '0;
      end
      ESPERA_SOLTAR: begin
        if (act_s) begin
          cnt_d = '0;
        end else if (cnt == CW'(DEBOUNCE_CICLOS - 1)) begin
          estado_d = REPOSO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        estado_d = REPOSO;
        cnt_d    = '0;
      end
    endcase
  end

  // Actions are computed on the edge entering ACEPTADA so the registered
  // strobes are high exactly during that state.
  always_comb begin
    aceptar     = (estado == FILTRANDO) && (estado_d == ACEPTADA);
    modo_cambio = (MODO_MONTO != modo_q);
    acc_base    = modo_cambio ? 32'd0 : acc;
    ndig_base   = modo_cambio ? '0 : ndig;
    acc_d       = acc_base;
    ndig_d      = ndig_base;
    dig_stb_d   = 1'b0;
    digito_d    = DIGITO;
    monto_stb_d = 1'b0;
    monto_d     = MONTO;
    inv_d       = 1'b0;
    if (aceptar) begin
      if (!MODO_MONTO) begin
        if (tec_s <= 4'd9) begin
          dig_stb_d = 1'b1;
          digito_d  = tec_s;
        end else begin
          inv_d = 1'b1;
        end
      end else if (tec_s <= 4'd9) begin
        if (ndig_base < DW'(MAX_DIGITOS_MONTO)) begin
          acc_d  = acc_base * 32'd10 + {28'd0, tec_s};
          ndig_d = ndig_base + DW'(1);
        end else begin
          inv_d = 1'b1;
        end
      end else if (tec_s == K_BORRAR) begin
        acc_d  = 32'd0;
        ndig_d = '0;
      end else if (tec_s == K_ENTER && ndig_base != '0) begin
        monto_d     = acc_base;
        monto_stb_d = 1'b1;
        acc_d       = 32'd0;
        ndig_d      = '0;
      end else begin
        inv_d = 1'b1;
      end
    end
  end

endmodule
